// File: rtl/teclado_pkg.sv
// Shared constants and types for the 4x4 keypad scanner: the no-key code,
// round-result and FSM encodings, and the (row, col) -> key code map.
package teclado_pkg;

    localparam logic [4:0] CODE_NONE = 5'd16;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_KEY   = 2'd1,
        RES_MULTI = 2'd2
    } res_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DEB     = 2'd1,
        ST_PRESSED = 2'd2,
        ST_REL     = 2'd3
    } state_t;

    // Indexed by {row, col}; entry 0 is r0c0.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'd1,  4'd2, 4'd3,  4'd10,
        4'd4,  4'd5, 4'd6,  4'd11,
        4'd7,  4'd8, 4'd9,  4'd12,
        4'd14, 4'd0, 4'd15, 4'd13
    };

endpackage

// File: rtl/teclado_matricial_sincronizador.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable
// reset value so idle (pulled-up) lines come out of reset inactive.
module sincronizador #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/teclado_matricial.sv
// 4x4 keypad scanner: walks the columns, gathers one round of row samples,
// and debounces whole rounds into a single key code plus one-cycle strobe.
module teclado_matricial
    import teclado_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int DEB_ROUNDS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic [4:0] digito,
    output logic       cambio_digito
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEB_ROUNDS + 1);

    logic [3:0]    w_filas;
    logic [SW-1:0] r_slot;
    logic [1:0]    r_col;
    logic [15:0]   r_acc;
    logic [15:0]   w_cur;
    logic [15:0]   w_hits;
    logic          w_tick;
    logic          w_round_end;
    logic [1:0]    w_nhits;
    logic [3:0]    w_idx;
    res_t          w_res;
    logic [3:0]    w_code;

    state_t        r_state, w_state_next;
    logic [3:0]    r_cand, w_cand_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          w_emit_next;
    logic [4:0]    r_digito;
    logic          r_cambio;

    sincronizador #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (filas),
        .o_q   (w_filas)
    );

    assign w_tick      = (r_slot == SW'(SCAN_DIV - 1));
    assign w_round_end = w_tick && (r_col == 2'd3);

    // Hits seen in the current column at this sample, placed at {row, col}.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_cur
            assign w_cur[gi] = w_tick && (r_col == 2'(gi % 4)) && !w_filas[gi / 4];
        end
    endgenerate

    assign w_hits = r_acc | w_cur;

    always_comb begin
        w_nhits = 2'd0;
        w_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_hits[i]) begin
                w_idx = 4'(i);
                if (w_nhits != 2'd2) w_nhits = w_nhits + 2'd1;
            end
        end
        case (w_nhits)
            2'd0:    w_res = RES_NONE;
            2'd1:    w_res = RES_KEY;
            default: w_res = RES_MULTI;
        endcase
        w_code = KEY_MAP[w_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot <= '0;
            r_col  <= 2'd0;
            r_acc  <= '0;
        end else begin
            if (w_tick) begin
                r_slot <= '0;
                r_col  <= r_col + 2'd1;
            end else begin
                r_slot <= r_slot + SW'(1);
            end
            r_acc <= w_round_end ? 16'd0 : w_hits;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cand   <= 4'd0;
            r_cnt    <= '0;
            r_digito <= CODE_NONE;
            r_cambio <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cand   <= w_cand_next;
            r_cnt    <= w_cnt_next;
            r_cambio <= w_emit_next;
            if (w_emit_next) r_digito <= {1'b0, r_cand};
        end
    end

    // FSM: next state, evaluated only when a round completes
    always_comb begin
        w_state_next = r_state;
        w_cand_next  = r_cand;
        w_cnt_next   = r_cnt;
        w_emit_next  = 1'b0;
        if (w_round_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_res == RES_KEY) begin
                        w_state_next = ST_DEB;
                        w_cand_next  = w_code;
                        w_cnt_next   = CW'(1);
                    end
                end
                ST_DEB: begin
                    if (w_res == RES_KEY && w_code == r_cand) begin
                        w_cnt_next = r_cnt + CW'(1);
                        if (r_cnt + CW'(1) == CW'(DEB_ROUNDS)) begin
                            w_state_next = ST_PRESSED;
                            w_emit_next  = 1'b1;
                        end
                    end else begin
                        w_state_next = ST_IDLE;
                        w_cnt_next   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (w_res == RES_NONE) begin
                        w_state_next = ST_REL;
                        w_cnt_next   = CW'(1);
                    end
                end
                default: begin
                    if (w_res == RES_NONE) begin
                        w_cnt_next = r_cnt + CW'(1);
                        if (r_cnt + CW'(1) == CW'(DEB_ROUNDS)) begin
                            w_state_next = ST_IDLE;
                            w_cnt_next   = '0;
                        end
                    end else begin
                        w_state_next = ST_PRESSED;
                    end
                end
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        columnas      = ~(4'b0001 << r_col);
        digito        = r_digito;
        cambio_digito = r_cambio;
    end

endmodule

// File: tb/tb_teclado_matricial.sv
// Directed bench for teclado_matricial with a behavioural keypad model
// (pressed keys pull their row low while their column is driven).
module tb_teclado_matricial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] filas;
    logic [3:0] columnas;
    logic [4:0] digito;
    logic       cambio_digito;

    logic [15:0] keys = '0;
    int          strobes = 0;
    int          total = 0;
    int          bad = 0;
    int          base;

    always #5 clk = ~clk;

    teclado_matricial #(
        .SCAN_DIV   (4),
        .DEB_ROUNDS (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .filas         (filas),
        .columnas      (columnas),
        .digito        (digito),
        .cambio_digito (cambio_digito)
    );

    always_comb begin
        filas = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !columnas[c]) filas[r] = 1'b0;
    end

    always @(posedge clk) if (cambio_digito === 1'b1) strobes <= strobes + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [3:0] exp_col;
        // 1. reset and column walk
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_columnas", columnas, 4'b1110);
        check("rst_digito", digito, 5'd16);
        check("rst_cambio", cambio_digito, 1'b0);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            check($sformatf("walk_%0d", k), columnas, exp_col);
        end

        // 2. single press r1c1 held 10 rounds
        base = strobes;
        keys[5] = 1'b1;
        cycles(160);
        check("press_strobes", strobes - base, 1);
        check("press_digito", digito, 5'd5);
        keys[5] = 1'b0;
        cycles(96);
        check("release_strobes", strobes - base, 1);
        check("release_digito", digito, 5'd5);

        // 3. bouncing r0c2, then a short release glitch
        base = strobes;
        for (int i = 0; i < 6; i++) begin
            keys[2] = (i % 2 == 0);
            cycles(5);
        end
        keys[2] = 1'b1;
        cycles(80);
        check("bounce_strobes", strobes - base, 1);
        check("bounce_digito", digito, 5'd3);
        keys[2] = 1'b0;
        cycles(16);
        keys[2] = 1'b1;
        cycles(80);
        check("glitch_strobes", strobes - base, 1);
        check("glitch_digito", digito, 5'd3);
        keys[2] = 1'b0;
        cycles(96);

        // 4. ghost press r0c0 + r0c1
        base = strobes;
        keys[0] = 1'b1;
        keys[1] = 1'b1;
        cycles(96);
        check("ghost_strobes", strobes - base, 0);
        check("ghost_digito", digito, 5'd3);
        keys[0] = 1'b0;
        keys[1] = 1'b0;
        cycles(96);

        // 5. sequence 2, 5, 5
        base = strobes;
        keys[1] = 1'b1;
        cycles(80);
        check("seq1_digito", digito, 5'd2);
        check("seq1_strobes", strobes - base, 1);
        keys[1] = 1'b0;
        cycles(80);
        keys[5] = 1'b1;
        cycles(80);
        check("seq2_digito", digito, 5'd5);
        check("seq2_strobes", strobes - base, 2);
        keys[5] = 1'b0;
        cycles(80);
        keys[5] = 1'b1;
        cycles(80);
        check("seq3_digito", digito, 5'd5);
        check("seq3_strobes", strobes - base, 3);
        keys[5] = 1'b0;
        cycles(96);

        // 6. reset in the middle of debouncing r3c3
        base = strobes;
        keys[15] = 1'b1;
        cycles(32);
        rst_n = 1'b0;
        cycles(2);
        check("midrst_columnas", columnas, 4'b1110);
        check("midrst_digito", digito, 5'd16);
        check("midrst_cambio", cambio_digito, 1'b0);
        check("midrst_strobes", strobes - base, 0);
        rst_n = 1'b1;
        cycles(44);
        check("postrst_early_strobes", strobes - base, 0);
        check("postrst_early_digito", digito, 5'd16);
        cycles(8);
        check("postrst_strobes", strobes - base, 1);
        check("postrst_digito", digito, 5'd13);
        keys[15] = 1'b0;
        cycles(16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/teclado_matricial.md
# teclado_matricial

Scanner and debouncer for the 4x4 matrix keypad. It drives the keypad columns one at a time, samples the rows, and debounces key presses over whole scan rounds. For each clean press it emits one 5-bit key code plus a single-cycle strobe. It sits directly upstream of the 3-digit RGB entry memory, which consumes `digito` and `cambio_digito`.

## Interface
- `SCAN_DIV`, default 50000: clock cycles per column slot; must be ≥ 4.
- `DEB_ROUNDS`, default 3: consecutive identical scan rounds needed to accept a press or a release; must be ≥ 2.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `filas`, input, 4: keypad rows; active-low, externally pulled up; asynchronous.
- `columnas`, output, 4: column drive; active-low, exactly one bit low at any time.
- `digito`, output, 5: last accepted key code, 0–15; 5'd16 = no key yet.
- `cambio_digito`, output, 1: one-cycle strobe marking a newly accepted key.

## Operation
- **Row synchronizer:** `filas` passes through a 2-flop synchronizer before any use.
- **Column scan:**
  - Slot counter runs 0..SCAN_DIV-1; column index advances c0→c1→c2→c3→c0 when the slot counter wraps.
  - `columnas` = ~(1 << col).
  - Rows are sampled at slot count SCAN_DIV-1.
- **Key map (row, col → code):**
  - r0: 1, 2, 3, 10
  - r1: 4, 5, 6, 11
  - r2: 7, 8, 9, 12
  - r3: 14, 0, 15, 13
- **Round result:** evaluated at the c3 sample, from all four column samples of the round.
  - NONE: no row low in any column.
  - KEY(code): exactly one (row, col) low in the whole round.
  - MULTI: two or more low.
- **FSM** (updates only on round results; candidate register `cand`, round counter `cnt`):
  - IDLE: KEY(k) → DEB with cand=k, cnt=1. NONE or MULTI → stay.
  - DEB: KEY(cand) → cnt+1. When cnt reaches DEB_ROUNDS → PRESSED and emit. Anything else → IDLE.
  - PRESSED: NONE → REL with cnt=1. Anything else → stay (held keys never repeat).
  - REL: NONE → cnt+1; when cnt reaches DEB_ROUNDS → IDLE. KEY or MULTI → PRESSED, no emit.
- **Emit:** `digito` ← cand and `cambio_digito` ← 1 on the same edge. `digito` holds until the next emit.
- **Invalid presses:** MULTI never emits. A changing candidate restarts debounce from IDLE.
- **Reset:** `rst_n`=0 at any clock edge, including mid-debounce, gives:
  - state IDLE, cnt=0, slot=0, col=c0
  - `columnas`=4'b1110, `digito`=5'd16, `cambio_digito`=0
  - synchronizer flops = 4'b1111

## Timing
- One round = 4·SCAN_DIV cycles. Rows are observed with 2 cycles of synchronizer delay; with SCAN_DIV ≥ 4 every sample sees at least one settled cycle.
- `cambio_digito` is high exactly 1 cycle: the cycle after the edge that processes the DEB_ROUNDS-th matching round result.
- Press latency: the key must be present for DEB_ROUNDS full rounds. Worst case is (DEB_ROUNDS+1)·4·SCAN_DIV + 3 cycles.
- `digito` is stable from the strobe edge onward, at least 4·SCAN_DIV cycles before any new strobe. This satisfies the downstream memory, which latches `digito` one cycle after the strobe.
- Minimum time between two accepted presses: 2·DEB_ROUNDS rounds (press plus release debounce).

## Structure
- Package `teclado_pkg` holds:
  - `CODE_NONE` = 5'd16
  - round-result encoding (NONE/KEY/MULTI)
  - FSM state enum {IDLE, DEB, PRESSED, REL}
  - key-map lookup as a 16-entry constant indexed by {row, col}
- One sub-module: `sincronizador` (2-flop, width parameter, reset value parameter). The scan counter, round accumulator and FSM stay in `teclado_matricial`.

## Test plan
All scenarios use SCAN_DIV=4 and DEB_ROUNDS=3 (round = 16 cycles).
1. **Reset:** hold `rst_n`=0 for 5 cycles → `columnas`=1110, `digito`=16, `cambio_digito`=0. After release, `columnas` walks 1110→1101→1011→0111, 4 cycles each.
2. **Single press:** press r1c1 for 10 rounds, then release → exactly one strobe with `digito`=5, no strobe for the rest of the hold, `digito` still 5 after release.
3. **Bounce:** toggle r0c2 every 5 cycles for 2 rounds, then hold steady for 5 rounds → exactly one strobe, `digito`=3. A 1-round release glitch while held gives no second strobe.
4. **Ghost press:** hold r0c0 and r0c1 together for 6 rounds → no strobe, `digito` unchanged.
5. **Sequence:** press/release r0c1, r1c1, r1c1 (5 rounds each, 5 rounds gap) → three strobes with `digito` 2, 5, 5. The downstream memory then reads c=2, d=5, u=5 with full=1.
6. **Reset mid-debounce:** press r3c3, assert reset after 2 rounds → no strobe, outputs at reset values. Keep holding → strobe with `digito`=13 after 3 further full rounds.
